aes_key_sched_ctrl: RTL and testbench

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

---
 rtl/aes_key_sched_ctrl.sv | 146 ++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: starts an external key-expansion engine, captures the
// 11 round keys into local storage and serves single-cycle round-key reads.
module aes_key_sched_ctrl (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         key_load,
   input  logic [127:0] key_in,
   output logic         key_ready,
   output logic         kx_start,
   output logic [127:0] kx_key,
   input  logic [127:0] kx_subkey,
   input  logic [3:0]   kx_cnt,
   input  logic         kx_valid,
   input  logic         rk_req,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_data,
   output logic         rk_valid,
   output logic         rk_err,
   output logic         keys_valid,
   output logic         kx_err
);

   localparam int unsigned NumKeys = 11;
   localparam logic [3:0]  LastRnd = 4'd10;
   localparam logic [3:0]  WdogMax = 4'd13;

   typedef enum logic [1:0] {StIdle, StStart, StExpand, StReady} state_e;

   state_e         state_q, state_d;
   logic [127:0]   kx_key_q, kx_key_d;
   logic [3:0]     exp_rnd_q, exp_rnd_d;
   logic [3:0]     wdog_q, wdog_d;
   logic           keys_valid_q, keys_valid_d;
   logic           kx_err_q, kx_err_d;
   logic [127:0]   rk_data_q, rk_data_d;
   logic           rk_valid_q, rk_valid_d;
   logic           rk_err_q, rk_err_d;
   logic [127:0]   slot_q [NumKeys];
   logic [127:0]   slot_d [NumKeys];

   logic           slot_we;
   logic [3:0]     slot_wa;
   logic [127:0]   slot_wd;
   logic           rd_ok;

   assign key_ready  = (state_q == StIdle) || (state_q == StReady);
   assign kx_start   = (state_q == StStart);
   assign kx_key     = kx_key_q;
   assign keys_valid = keys_valid_q;
   assign kx_err     = kx_err_q;
   assign rk_data    = rk_data_q;
   assign rk_valid   = rk_valid_q;
   assign rk_err     = rk_err_q;

   always_comb begin
      state_d      = state_q;
      kx_key_d     = kx_key_q;
      exp_rnd_d    = exp_rnd_q;
      wdog_d       = wdog_q;
      keys_valid_d = keys_valid_q;
      kx_err_d     = kx_err_q;
      slot_we      = 1'b0;
      slot_wa      = 4'd0;
      slot_wd      = '0;
      unique case (state_q)
         StIdle, StReady: begin
            if (key_load) begin
               state_d      = StStart;
               kx_key_d     = key_in;
               slot_we      = 1'b1;
               slot_wa      = 4'd0;
               slot_wd      = key_in;
               keys_valid_d = 1'b0;
               kx_err_d     = 1'b0;
               exp_rnd_d    = 4'd1;
               wdog_d       = 4'd0;
            end
         end
         StStart: begin
            state_d = StExpand;
         end
         StExpand: begin
            wdog_d = wdog_q + 4'd1;
            if (kx_valid && (kx_cnt == exp_rnd_q)) begin
               slot_we   = 1'b1;
               slot_wa   = exp_rnd_q;
               slot_wd   = kx_subkey;
               exp_rnd_d = exp_rnd_q + 4'd1;
               if (exp_rnd_q == LastRnd) begin
                  state_d      = StReady;
                  keys_valid_d = 1'b1;
               end
            end else if (kx_valid || (wdog_q == WdogMax)) begin
               // Out-of-order round or the 14th EXPAND cycle without finishing.
               kx_err_d = 1'b1;
               state_d  = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      slot_d = slot_q;
      if (slot_we) begin
         slot_d[slot_wa] = slot_wd;
      end
   end

   // Reads sample the pre-edge storage, so a read alongside a key accept sees the old set.
   always_comb begin
      rd_ok      = rk_req && keys_valid_q && (rk_idx <= LastRnd);
      rk_valid_d = rd_ok;
      rk_err_d   = rk_req && !rd_ok;
      rk_data_d  = rd_ok ? slot_q[rk_idx] : rk_data_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         kx_key_q     <= '0;
         exp_rnd_q    <= 4'd1;
         wdog_q       <= 4'd0;
         keys_valid_q <= 1'b0;
         kx_err_q     <= 1'b0;
         rk_data_q    <= '0;
         rk_valid_q   <= 1'b0;
         rk_err_q     <= 1'b0;
         for (int i = 0; i < NumKeys; i++) begin
            slot_q[i] <= '0;
         end
      end else begin
         state_q      <= state_d;
         kx_key_q     <= kx_key_d;
         exp_rnd_q    <= exp_rnd_d;
         wdog_q       <= wdog_d;
         keys_valid_q <= keys_valid_d;
         kx_err_q     <= kx_err_d;
         rk_data_q    <= rk_data_d;
         rk_valid_q   <= rk_valid_d;
         rk_err_q     <= rk_err_d;
         slot_q       <= slot_d;
      end
   end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: behavioural AES-128 expansion engine with fault modes and a
// read-response scoreboard.
module tb_aes_key_sched_ctrl;

   localparam int EngGood   = 0;
   localparam int EngSkip5  = 1;
   localparam int EngSilent = 2;

   localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K3 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KJ = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         key_load;
   logic [127:0] key_in;
   logic         key_ready;
   logic         kx_start;
   logic [127:0] kx_key;
   logic [127:0] kx_subkey;
   logic [3:0]   kx_cnt;
   logic         kx_valid;
   logic         rk_req;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic         rk_valid;
   logic         rk_err;
   logic         keys_valid;
   logic         kx_err;

   aes_key_sched_ctrl dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .key_load   (key_load),
      .key_in     (key_in),
      .key_ready  (key_ready),
      .kx_start   (kx_start),
      .kx_key     (kx_key),
      .kx_subkey  (kx_subkey),
      .kx_cnt     (kx_cnt),
      .kx_valid   (kx_valid),
      .rk_req     (rk_req),
      .rk_idx     (rk_idx),
      .rk_data    (rk_data),
      .rk_valid   (rk_valid),
      .rk_err     (rk_err),
      .keys_valid (keys_valid),
      .kx_err     (kx_err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic         err;
      logic [127:0] data;
   } rd_exp_t;

   rd_exp_t      sb_q [$];
   int           n_checks = 0;
   int           n_errors = 0;
   int           eng_mode = EngGood;
   logic [7:0]   sbox [256];
   logic [127:0] m_slot [11];
   bit           m_kv;
   logic [127:0] m_last;
   logic [1407:0] eng_flat;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      logic [15:0] d;
      d = {v, v} << n;
      return d[15:8];
   endfunction

   task automatic init_sbox();
      logic [7:0] inv;
      logic [7:0] xb;
      logic [7:0] yb;
      for (int x = 0; x < 256; x++) begin
         xb  = x[7:0];
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            yb = y[7:0];
            if (gmul(xb, yb) == 8'h01) inv = yb;
         end
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [1407:0] expand_key(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rcon;
      logic [1407:0] flat;
      w[0] = key[127:96];
      w[1] = key[95:64];
      w[2] = key[63:32];
      w[3] = key[31:0];
      rcon = 8'h01;
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h0};
            rcon = rcon[7] ? ({rcon[6:0], 1'b0} ^ 8'h1b) : {rcon[6:0], 1'b0};
         end
         w[i] = w[i-4] ^ t;
      end
      flat = '0;
      for (int r = 0; r < 11; r++) begin
         flat[r*128 +: 128] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      end
      return flat;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Engine model: presents round r one cycle after the start pulse is seen, per mode.
   initial begin
      int cnt;
      kx_valid  = 1'b0;
      kx_cnt    = 4'd0;
      kx_subkey = '0;
      forever begin
         @(posedge clk);
         #1;
         if (reset_n && kx_start) begin
            eng_flat = expand_key(kx_key);
            for (int r = 1; r <= 10; r++) begin
               @(posedge clk);
               #1;
               if (!reset_n) break;
               cnt = (eng_mode == EngSkip5 && r >= 5) ? r + 1 : r;
               if (eng_mode == EngSilent || cnt > 10) begin
                  kx_valid = 1'b0;
               end else begin
                  kx_valid  = 1'b1;
                  kx_cnt    = cnt[3:0];
                  kx_subkey = eng_flat[cnt*128 +: 128];
               end
            end
            if (reset_n) begin
               @(posedge clk);
               #1;
            end
            kx_valid = 1'b0;
            kx_cnt   = 4'd0;
         end
      end
   end

   // Read-response scoreboard.
   initial begin
      rd_exp_t e;
      forever begin
         @(negedge clk);
         if (rk_valid || rk_err) begin
            if (sb_q.size() == 0) begin
               chk("rd_unexpected", 1'b1, 1'b0);
            end else begin
               e = sb_q.pop_front();
               chk("rd_err", rk_err, e.err);
               chk("rd_valid", rk_valid, !e.err);
               chk("rd_data", rk_data, e.data);
            end
         end
      end
   end

   task automatic push_rd(input logic [3:0] idx, input logic [127:0] want);
      rd_exp_t e;
      bit ok;
      ok = m_kv && (idx <= 4'd10);
      if (ok) m_last = want;
      e.err  = !ok;
      e.data = m_last;
      sb_q.push_back(e);
   endtask

   task automatic rd(input logic [3:0] idx, input logic [127:0] want);
      push_rd(idx, want);
      rk_req = 1'b1;
      rk_idx = idx;
      tick();
      rk_req = 1'b0;
   endtask

   // Accept at T; returns at T+2.
   task automatic load_key(input logic [127:0] key);
      logic [1407:0] flat;
      flat = expand_key(key);
      for (int r = 0; r < 11; r++) m_slot[r] = flat[r*128 +: 128];
      key_load = 1'b1;
      key_in   = key;
      tick();
      m_kv     = 1'b0;
      key_load = 1'b0;
      rk_req   = 1'b0;
      chk("kx_start_t1", kx_start, 1'b1);
      chk("kx_key_t1", kx_key, key);
      chk("keys_valid_t1", keys_valid, 1'b0);
      chk("kx_err_t1", kx_err, 1'b0);
      chk("key_ready_t1", key_ready, 1'b0);
      tick();
      chk("kx_start_t2", kx_start, 1'b0);
   endtask

   task automatic finish_expand(input int from);
      for (int k = from; k < 12; k++) begin
         chk("keys_valid_low", keys_valid, 1'b0);
         tick();
      end
      chk("keys_valid_t12", keys_valid, 1'b1);
      chk("key_ready_t12", key_ready, 1'b1);
      m_kv = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation bound reached");
      $fatal(1);
   end

   initial begin
      reset_n  = 1'b1;
      key_load = 1'b0;
      key_in   = '0;
      rk_req   = 1'b0;
      rk_idx   = 4'd0;
      m_kv     = 1'b0;
      m_last   = '0;
      for (int r = 0; r < 11; r++) m_slot[r] = '0;
      init_sbox();
      #2 reset_n = 1'b0;
      #1;
      chk("rst_key_ready", key_ready, 1'b1);
      chk("rst_kx_start", kx_start, 1'b0);
      chk("rst_kx_key", kx_key, '0);
      chk("rst_rk_data", rk_data, '0);
      chk("rst_rk_valid", rk_valid, 1'b0);
      chk("rst_rk_err", rk_err, 1'b0);
      chk("rst_keys_valid", keys_valid, 1'b0);
      chk("rst_kx_err", kx_err, 1'b0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();

      rd(4'd3, '0);

      // Good load with an ignored key_load mid-expansion.
      load_key(K1);
      key_load = 1'b1;
      key_in   = KJ;
      tick();
      key_load = 1'b0;
      finish_expand(3);
      rd(4'd1, 128'ha0fafe1788542cb123a339392a6c7605);
      rd(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      rd(4'd0, K1);
      rd(4'd11, '0);

      // Engine skips round 5.
      eng_mode = EngSkip5;
      load_key(K3);
      for (int k = 0; k < 4; k++) tick();
      chk("skip_kx_err_t6", kx_err, 1'b0);
      tick();
      chk("skip_kx_err_t7", kx_err, 1'b1);
      chk("skip_keys_valid", keys_valid, 1'b0);
      chk("skip_key_ready", key_ready, 1'b1);
      rd(4'd2, '0);
      for (int k = 0; k < 6; k++) tick();
      eng_mode = EngGood;
      load_key(K1);
      finish_expand(2);

      // Engine never reports a round.
      eng_mode = EngSilent;
      load_key(K3);
      for (int k = 0; k < 13; k++) tick();
      chk("wdog_kx_err_t15", kx_err, 1'b0);
      tick();
      chk("wdog_kx_err_t16", kx_err, 1'b1);
      chk("wdog_key_ready", key_ready, 1'b1);
      chk("wdog_keys_valid", keys_valid, 1'b0);
      eng_mode = EngGood;

      // Asynchronous reset mid-expansion.
      load_key(K3);
      for (int k = 0; k < 4; k++) tick();
      #2 reset_n = 1'b0;
      #1;
      chk("arst_kx_key", kx_key, '0);
      chk("arst_rk_data", rk_data, '0);
      chk("arst_key_ready", key_ready, 1'b1);
      chk("arst_kx_start", kx_start, 1'b0);
      chk("arst_keys_valid", keys_valid, 1'b0);
      m_kv   = 1'b0;
      m_last = '0;
      tick();
      tick();
      #2 reset_n = 1'b1;
      #1;
      chk("post_rst_key_ready", key_ready, 1'b1);
      load_key(K3);
      finish_expand(2);
      rd(4'd2, m_slot[2]);

      // Reload in READY with a read on the accept cycle.
      push_rd(4'd1, m_slot[1]);
      rk_req = 1'b1;
      rk_idx = 4'd1;
      load_key(K2);
      finish_expand(2);
      rd(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5);
      rd(4'd0, K2);

      tick();
      tick();
      chk("sb_empty", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
